// File: rtl/cb_synthesis.sv
// cb_synthesis: depth-first walk of a Huffman tree held in SRAM, emitting each leaf's
// character and bit path to the codebook writer with a write_finish handshake.
module cb_synthesis (
    input  logic         clk,
    input  logic         rst,
    input  logic         SRAM_enable,
    input  logic [6:0]   max_index,
    input  logic [70:0]  h_element,
    input  logic         write_finish,
    output logic [6:0]   curr_index,
    output logic [2:0]   curr_state,
    output logic [127:0] curr_path,
    output logic [6:0]   pos,
    output logic [127:0] char_path,
    output logic [6:0]   track_length,
    output logic [7:0]   char_index,
    output logic         char_found,
    output logic [8:0]   least1,
    output logic [8:0]   least2,
    output logic [3:0]   finished,
    output logic         wait_cycle
);
    typedef enum logic [2:0] {
        LEFT = 3'd0, RIGHT = 3'd1, TRACK = 3'd2, BACKTRACK = 3'd3,
        FINISH = 3'd4, INIT = 3'd5, SEND = 3'd6
    } state_t;

    state_t         r_state, r_ret, w_state_n, w_ret_n;
    logic [6:0]     r_index, r_pos, r_tlen, r_cnt, w_index_n, w_pos_n, w_tlen_n, w_cnt_n;
    logic [127:0]   r_path, r_cpath, w_path_n, w_cpath_n;
    logic [7:0]     r_char, w_char_n;
    logic [8:0]     r_l1, r_l2, w_l1_n, w_l2_n;
    logic [3:0]     r_fin, w_fin_n;
    logic           r_found, r_wait, w_found_n, w_wait_n;

    logic [8:0]     w_left, w_right;
    logic           w_l_leaf, w_l_node, w_r_leaf, w_r_node;
    logic [6:0]     w_pm1;
    logic [127:0]   w_bit, w_keep;
    logic           w_unused;

    assign w_left   = h_element[63:55];
    assign w_right  = h_element[54:46];
    assign w_unused = ^{h_element[70:64], h_element[45:0]};
    assign w_l_leaf = !w_left[8];
    assign w_l_node = w_left[8] && !w_left[7];
    assign w_r_leaf = !w_right[8];
    assign w_r_node = w_right[8] && !w_right[7];
    assign w_bit    = 128'd1 << r_pos;
    assign w_pm1    = r_pos - 7'd1;
    // keeps bits below pos-1; everything from the popped level upward is discarded
    assign w_keep   = ~({128{1'b1}} << w_pm1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= INIT;
            r_ret   <= LEFT;
            r_index <= '0;
            r_pos   <= '0;
            r_tlen  <= '0;
            r_cnt   <= '0;
            r_path  <= '0;
            r_cpath <= '0;
            r_char  <= '0;
            r_l1    <= '0;
            r_l2    <= '0;
            r_fin   <= '0;
            r_found <= 1'b0;
            r_wait  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_ret   <= w_ret_n;
            r_index <= w_index_n;
            r_pos   <= w_pos_n;
            r_tlen  <= w_tlen_n;
            r_cnt   <= w_cnt_n;
            r_path  <= w_path_n;
            r_cpath <= w_cpath_n;
            r_char  <= w_char_n;
            r_l1    <= w_l1_n;
            r_l2    <= w_l2_n;
            r_fin   <= w_fin_n;
            r_found <= w_found_n;
            r_wait  <= w_wait_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_ret_n   = r_ret;
        w_index_n = r_index;
        w_pos_n   = r_pos;
        w_tlen_n  = r_tlen;
        w_cnt_n   = r_cnt;
        w_path_n  = r_path;
        w_cpath_n = r_cpath;
        w_char_n  = r_char;
        w_l1_n    = r_l1;
        w_l2_n    = r_l2;
        w_fin_n   = r_fin;
        w_found_n = r_found;
        if (SRAM_enable && !r_wait) begin
            case (r_state)
                INIT: begin
                    w_index_n = max_index;
                    w_pos_n   = '0;
                    w_path_n  = '0;
                    w_fin_n   = '0;
                    w_state_n = LEFT;
                end
                LEFT: begin
                    w_l1_n = w_left;
                    w_l2_n = w_right;
                    if (w_l_node) begin
                        w_path_n  = r_path & ~w_bit;
                        w_pos_n   = r_pos + 7'd1;
                        w_index_n = w_left[6:0];
                    end else if (w_l_leaf) begin
                        w_cpath_n = r_path & ~w_bit;
                        w_tlen_n  = r_pos + 7'd1;
                        w_char_n  = w_left[7:0];
                        w_found_n = 1'b1;
                        w_ret_n   = RIGHT;
                        w_state_n = SEND;
                    end else begin
                        w_state_n = RIGHT;
                    end
                end
                RIGHT: begin
                    if (w_r_node) begin
                        w_path_n  = r_path | w_bit;
                        w_pos_n   = r_pos + 7'd1;
                        w_index_n = w_right[6:0];
                        w_state_n = LEFT;
                    end else if (w_r_leaf) begin
                        w_cpath_n = r_path | w_bit;
                        w_tlen_n  = r_pos + 7'd1;
                        w_char_n  = w_right[7:0];
                        w_found_n = 1'b1;
                        w_ret_n   = BACKTRACK;
                        w_state_n = SEND;
                    end else begin
                        w_state_n = BACKTRACK;
                    end
                end
                SEND: begin
                    if (write_finish) begin
                        w_found_n = 1'b0;
                        w_state_n = r_ret;
                    end
                end
                BACKTRACK: begin
                    if (r_pos == 7'd0) begin
                        w_fin_n   = 4'b0101;
                        w_state_n = FINISH;
                    end else begin
                        w_pos_n = w_pm1;
                        // a left branch at this level still has an unexplored right sibling
                        if (!r_path[w_pm1]) begin
                            w_path_n  = r_path & w_keep;
                            w_index_n = max_index;
                            w_cnt_n   = '0;
                            w_state_n = TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (r_cnt < r_pos) begin
                        w_index_n = r_path[r_cnt] ? w_right[6:0] : w_left[6:0];
                        w_cnt_n   = r_cnt + 7'd1;
                    end else begin
                        w_state_n = RIGHT;
                    end
                end
                FINISH: begin
                    w_fin_n   = 4'b0101;
                    w_found_n = 1'b0;
                end
                default: w_state_n = INIT;
            endcase
        end
        w_wait_n = SRAM_enable ? (w_index_n != r_index) : r_wait;
    end

    assign curr_index   = r_index;
    assign curr_state   = r_state;
    assign curr_path    = r_path;
    assign pos          = r_pos;
    assign char_path    = r_cpath;
    assign track_length = r_tlen;
    assign char_index   = r_char;
    assign char_found   = r_found;
    assign least1       = r_l1;
    assign least2       = r_l2;
    assign finished     = r_fin;
    assign wait_cycle   = r_wait;
endmodule

// File: tb/tb_cb_synthesis.sv
// tb_cb_synthesis: directed checks of cb_synthesis on a single-node tree and a 9-node tree,
// covering handshake hold, mid-run reset and an SRAM_enable stall.
module tb_cb_synthesis;
    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         SRAM_enable = 1'b1;
    logic         write_finish = 1'b0;
    logic [6:0]   max_index = '0;
    logic [70:0]  h_element;
    logic [6:0]   curr_index, pos, track_length;
    logic [2:0]   curr_state;
    logic [127:0] curr_path, char_path;
    logic [7:0]   char_index;
    logic         char_found, wait_cycle;
    logic [8:0]   least1, least2;
    logic [3:0]   finished;

    logic [70:0]  htree [0:127];
    int           n_checks = 0;
    int           n_errors = 0;

    logic [7:0]   exp_char [10] = '{8'd67, 8'd66, 8'd65, 8'd70, 8'd68, 8'd69, 8'd74, 8'd71, 8'd72, 8'd73};
    logic [127:0] exp_path [10] = '{128'd0, 128'd8, 128'd4, 128'd2, 128'd6, 128'd14, 128'd1, 128'd3, 128'd7, 128'd15};
    logic [6:0]   exp_len  [10] = '{7'd4, 7'd4, 7'd3, 7'd3, 7'd4, 7'd4, 7'd2, 7'd3, 7'd4, 7'd4};

    cb_synthesis dut (
        .clk(clk), .rst(rst), .SRAM_enable(SRAM_enable), .max_index(max_index),
        .h_element(h_element), .write_finish(write_finish), .curr_index(curr_index),
        .curr_state(curr_state), .curr_path(curr_path), .pos(pos), .char_path(char_path),
        .track_length(track_length), .char_index(char_index), .char_found(char_found),
        .least1(least1), .least2(least2), .finished(finished), .wait_cycle(wait_cycle)
    );

    always #5 clk = ~clk;
    assign h_element = htree[curr_index];

    function automatic logic [8:0] leaf(input logic [7:0] c);
        return {1'b0, c};
    endfunction

    function automatic logic [8:0] node(input logic [6:0] n);
        return {2'b10, n};
    endfunction

    // ignored fields carry junk so the DUT must not depend on them
    function automatic logic [70:0] mk(input logic [8:0] l, input logic [8:0] r);
        return {7'h7F, l, r, 46'h1234};
    endfunction

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_found(input string tag);
        int c = 0;
        while (!char_found && c < 400) begin
            tick();
            c++;
        end
        check({tag, "_found"}, 128'(char_found), 128'd1);
    endtask

    task automatic ack();
        write_finish = 1'b1;
        tick();
        write_finish = 1'b0;
    endtask

    task automatic emit(input int k);
        wait_found($sformatf("e%0d", k));
        check($sformatf("e%0d_char", k), 128'(char_index), 128'(exp_char[k]));
        check($sformatf("e%0d_path", k), char_path, exp_path[k]);
        check($sformatf("e%0d_len", k), 128'(track_length), 128'(exp_len[k]));
        ack();
    endtask

    task automatic wait_finish(input string tag);
        int c = 0;
        while (finished != 4'b0101 && c < 400) begin
            tick();
            c++;
        end
        check({tag, "_finished"}, 128'(finished), 128'd5);
        check({tag, "_fstate"}, 128'(curr_state), 128'd4);
        check({tag, "_ffound"}, 128'(char_found), 128'd0);
    endtask

    task automatic run_seq(input int from, input string tag);
        for (int k = from; k < 10; k++) emit(k);
        wait_finish(tag);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_state"}, 128'(curr_state), 128'd5);
        check({tag, "_index"}, 128'(curr_index), 128'd0);
        check({tag, "_pos"}, 128'(pos), 128'd0);
        check({tag, "_cpath"}, curr_path, 128'd0);
        check({tag, "_chpath"}, char_path, 128'd0);
        check({tag, "_len"}, 128'(track_length), 128'd0);
        check({tag, "_char"}, 128'(char_index), 128'd0);
        check({tag, "_found"}, 128'(char_found), 128'd0);
        check({tag, "_least"}, 128'({least1, least2}), 128'd0);
        check({tag, "_fin"}, 128'(finished), 128'd0);
        check({tag, "_wait"}, 128'(wait_cycle), 128'd0);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) htree[i] = '0;
        htree[0] = mk(leaf(8'd67), 9'h180);
        tick();
        tick();
        check_zero("rst");
        rst = 1'b1;
        wait_found("single");
        check("single_char", 128'(char_index), 128'd67);
        check("single_path", char_path, 128'd0);
        check("single_len", 128'(track_length), 128'd1);
        check("single_l1", 128'(least1), 128'h043);
        check("single_l2", 128'(least2), 128'h180);
        ack();
        wait_finish("single");

        htree[8] = mk(node(7'd6), node(7'd7));
        htree[6] = mk(node(7'd3), node(7'd4));
        htree[3] = mk(node(7'd0), leaf(8'd65));
        htree[0] = mk(leaf(8'd67), leaf(8'd66));
        htree[4] = mk(leaf(8'd70), node(7'd1));
        htree[1] = mk(leaf(8'd68), leaf(8'd69));
        htree[7] = mk(leaf(8'd74), node(7'd5));
        htree[5] = mk(leaf(8'd71), node(7'd2));
        htree[2] = mk(leaf(8'd72), leaf(8'd73));
        max_index = 7'd8;
        do_reset();
        wait_found("hs");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("hs%0d_state", i), 128'(curr_state), 128'd6);
            check($sformatf("hs%0d_found", i), 128'(char_found), 128'd1);
            check($sformatf("hs%0d_char", i), 128'(char_index), 128'd67);
            check($sformatf("hs%0d_path", i), char_path, 128'd0);
            if (i < 5) tick();
        end
        ack();
        run_seq(1, "tree");

        do_reset();
        write_finish = 1'b1;
        for (int c = 0; c < 400 && curr_index != 7'd4; c++) tick();
        check("mid_reach", 128'(curr_index), 128'd4);
        write_finish = 1'b0;
        rst = 1'b0;
        tick();
        check_zero("mid");
        rst = 1'b1;
        run_seq(0, "mid");

        do_reset();
        emit(0);
        emit(1);
        for (int c = 0; c < 400 && curr_state != 3'd2; c++) tick();
        check("stall_reach", 128'(curr_state), 128'd2);
        SRAM_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("st%0d_state", i), 128'(curr_state), 128'd2);
            check($sformatf("st%0d_index", i), 128'(curr_index), 128'd8);
            check($sformatf("st%0d_pos", i), 128'(pos), 128'd2);
            check($sformatf("st%0d_cpath", i), curr_path, 128'd0);
            check($sformatf("st%0d_wait", i), 128'(wait_cycle), 128'd1);
            check($sformatf("st%0d_char", i), 128'(char_index), 128'd66);
            check($sformatf("st%0d_chpath", i), char_path, 128'd8);
            check($sformatf("st%0d_found", i), 128'(char_found), 128'd0);
        end
        SRAM_enable = 1'b1;
        run_seq(2, "stall");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
